// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter sharing the data_mem read/write port pair
// between two requesters, with bounded locked bursts and registered read data.
module dmem_arbiter #(
    parameter int ADDR_W    = 7,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m1_req,
    input  logic              m0_we,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic [2:0]        m0_strb,
    input  logic [2:0]        m1_strb,
    input  logic              m0_lock,
    input  logic              m1_lock,
    output logic              m0_gnt,
    output logic              m1_gnt,
    output logic              m0_rvalid,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_dout,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [DATA_W-1:0] mem_wr_din,
    output logic              mem_we,
    output logic [2:0]        mem_wr_strb
);

    localparam int CNT_W = $clog2(MAX_BURST) + 1;

    logic             last;
    logic             lock_active;
    logic             owner;
    logic [CNT_W-1:0] cnt;

    logic             last_d;
    logic             lock_active_d;
    logic             owner_d;
    logic [CNT_W-1:0] cnt_d;

    logic             gnt_any;
    logic             gnt_sel;
    logic             sel_lock;
    logic [CNT_W-1:0] beat_cnt;

    // Arbitration state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last        <= 1'b1;
            lock_active <= 1'b0;
            owner       <= 1'b0;
            cnt         <= '0;
        end else begin
            last        <= last_d;
            lock_active <= lock_active_d;
            owner       <= owner_d;
            cnt         <= cnt_d;
        end
    end

    // Grant selection: live lock first, then single requester, then round-robin tie-break
    always_comb begin
        gnt_any = 1'b0;
        gnt_sel = 1'b0;
        if (rst) begin
            if (lock_active && (owner ? m1_req : m0_req)) begin
                gnt_any = 1'b1;
                gnt_sel = owner;
            end else if (m0_req && m1_req) begin
                gnt_any = 1'b1;
                gnt_sel = ~last;
            end else if (m0_req) begin
                gnt_any = 1'b1;
                gnt_sel = 1'b0;
            end else if (m1_req) begin
                gnt_any = 1'b1;
                gnt_sel = 1'b1;
            end
        end
    end

    assign m0_gnt = gnt_any && !gnt_sel;
    assign m1_gnt = gnt_any && gnt_sel;

    // Next arbitration state: burst counting continues only for the same lock holder
    always_comb begin
        last_d        = last;
        lock_active_d = lock_active;
        owner_d       = owner;
        cnt_d         = cnt;
        sel_lock      = gnt_sel ? m1_lock : m0_lock;
        beat_cnt      = ((lock_active && (owner == gnt_sel)) ? cnt : '0) + CNT_W'(1);
        if (gnt_any) begin
            last_d = gnt_sel;
            if (sel_lock && (beat_cnt < CNT_W'(MAX_BURST))) begin
                lock_active_d = 1'b1;
                owner_d       = gnt_sel;
                cnt_d         = beat_cnt;
            end else begin
                lock_active_d = 1'b0;
                cnt_d         = '0;
            end
        end else begin
            // No grant means either no lock or the owner dropped req: the lock is void
            lock_active_d = 1'b0;
            cnt_d         = '0;
        end
    end

    // Memory port drive from the granted master, zero when idle
    always_comb begin
        mem_rd_addr = '0;
        mem_wr_addr = '0;
        mem_wr_din  = '0;
        mem_we      = 1'b0;
        mem_wr_strb = '0;
        if (gnt_any) begin
            mem_rd_addr = gnt_sel ? m1_addr  : m0_addr;
            mem_wr_addr = gnt_sel ? m1_addr  : m0_addr;
            mem_wr_din  = gnt_sel ? m1_wdata : m0_wdata;
            mem_we      = gnt_sel ? m1_we    : m0_we;
            mem_wr_strb = gnt_sel ? m1_strb  : m0_strb;
        end
    end

    // Per-master read return: capture on read grant, rvalid pulses for one cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
        end else begin
            m0_rvalid <= m0_gnt && !m0_we;
            m1_rvalid <= m1_gnt && !m1_we;
            if (m0_gnt && !m0_we) m0_rdata <= mem_rd_dout;
            if (m1_gnt && !m1_we) m1_rdata <= mem_rd_dout;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized
// traffic against a behavioural reference model.
module tb_dmem_arbiter;

    localparam int AW = 7;
    localparam int DW = 32;
    localparam int MB = 4;

    logic          clk;
    logic          rst;
    logic          m0_req, m1_req, m0_we, m1_we, m0_lock, m1_lock;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic [2:0]    m0_strb, m1_strb;
    logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic [AW-1:0] mem_rd_addr, mem_wr_addr;
    logic [DW-1:0] mem_rd_dout, mem_wr_din;
    logic          mem_we;
    logic [2:0]    mem_wr_strb;

    int n_tests = 0;
    int n_fail  = 0;

    // data_mem stand-in and a separate reference copy for expectations
    logic [DW-1:0] mem     [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];

    assign mem_rd_dout = mem[mem_rd_addr];
    always @(posedge clk) if (mem_we) mem[mem_wr_addr] <= mem_wr_din;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m1_req(m1_req), .m0_we(m0_we), .m1_we(m1_we),
        .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
        .m0_strb(m0_strb), .m1_strb(m1_strb), .m0_lock(m0_lock), .m1_lock(m1_lock),
        .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
        .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
        .mem_rd_addr(mem_rd_addr), .mem_rd_dout(mem_rd_dout),
        .mem_wr_addr(mem_wr_addr), .mem_wr_din(mem_wr_din),
        .mem_we(mem_we), .mem_wr_strb(mem_wr_strb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs;
        m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0; m0_lock = 0; m1_lock = 0;
        m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0; m0_strb = '0; m1_strb = '0;
    endtask

    task automatic do_reset;
        clear_inputs();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #1 rst = 1'b0;
        m0_req = 1; m1_req = 1; m0_we = 1; m1_we = 0; m0_lock = 1; m1_lock = 1;
        m0_addr = 7'd9; m1_addr = 7'd10; m0_wdata = 32'h1234_5678; m1_wdata = 32'hCAFE_0001;
        m0_strb = 3'b111; m1_strb = 3'b101;
        @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({m0_gnt, m1_gnt} !== 2'b00) begin
            n_fail++; $display("FAIL reset_gnt: got %b want 00", {m0_gnt, m1_gnt});
        end
        n_tests++;
        if ({m0_rvalid, m1_rvalid} !== 2'b00 || m0_rdata !== '0 || m1_rdata !== '0) begin
            n_fail++; $display("FAIL reset_rdata: got rv=%b d0=%h d1=%h want all 0",
                               {m0_rvalid, m1_rvalid}, m0_rdata, m1_rdata);
        end
        n_tests++;
        if (mem_rd_addr !== '0 || mem_wr_addr !== '0 || mem_wr_din !== '0 || mem_we !== 1'b0 || mem_wr_strb !== '0) begin
            n_fail++; $display("FAIL reset_mem: got ra=%h wa=%h din=%h we=%b strb=%b want all 0",
                               mem_rd_addr, mem_wr_addr, mem_wr_din, mem_we, mem_wr_strb);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        clear_inputs();
    endtask

    task automatic test_fairness;
        logic [DW-1:0] d2, d3;
        do_reset();
        d2 = $urandom; d3 = $urandom;
        mem[2] = d2; mem[3] = d3;
        m0_req = 1; m1_req = 1; m0_addr = 7'd2; m1_addr = 7'd3;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin m0_req = 0; m1_req = 0; end
            @(negedge clk);
            n_tests++;
            if (i < 4 && (m0_gnt !== (i % 2 == 0) || m1_gnt !== (i % 2 == 1))) begin
                n_fail++; $display("FAIL fair_gnt[%0d]: got %b%b want m%0d", i, m0_gnt, m1_gnt, i % 2);
            end else if (i == 4 && {m0_gnt, m1_gnt} !== 2'b00) begin
                n_fail++; $display("FAIL fair_idle: got %b%b want 00", m0_gnt, m1_gnt);
            end
            n_tests++;
            if (i > 0 && (m0_rvalid !== ((i - 1) % 2 == 0) || m1_rvalid !== ((i - 1) % 2 == 1))) begin
                n_fail++; $display("FAIL fair_rvalid[%0d]: got %b%b", i, m0_rvalid, m1_rvalid);
            end else if (i == 0 && {m0_rvalid, m1_rvalid} !== 2'b00) begin
                n_fail++; $display("FAIL fair_rvalid0: got %b%b want 00", m0_rvalid, m1_rvalid);
            end
            n_tests++;
            if (i == 4 && (m0_rdata !== d2 || m1_rdata !== d3)) begin
                n_fail++; $display("FAIL fair_rdata: got %h/%h want %h/%h", m0_rdata, m1_rdata, d2, d3);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_write_read;
        do_reset();
        mem[5] = 32'h0;
        m1_req = 1; m1_we = 1; m1_addr = 7'd5; m1_wdata = 32'hDEADBEEF; m1_strb = 3'b010;
        @(negedge clk);
        n_tests++;
        if (m1_gnt !== 1'b1 || mem_we !== 1'b1 || mem_wr_addr !== 7'd5 ||
            mem_wr_din !== 32'hDEADBEEF || mem_wr_strb !== 3'b010) begin
            n_fail++; $display("FAIL wr_drive: got gnt=%b we=%b wa=%0d din=%h strb=%b want 1 1 5 deadbeef 010",
                               m1_gnt, mem_we, mem_wr_addr, mem_wr_din, mem_wr_strb);
        end
        @(posedge clk); #1;
        m1_req = 0; m1_we = 0;
        m0_req = 1; m0_we = 0; m0_addr = 7'd5;
        @(negedge clk);
        n_tests++;
        if (m0_gnt !== 1'b1 || mem_we !== 1'b0 || mem_rd_addr !== 7'd5 || m1_rvalid !== 1'b0) begin
            n_fail++; $display("FAIL rd_drive: got gnt=%b we=%b ra=%0d m1_rv=%b want 1 0 5 0",
                               m0_gnt, mem_we, mem_rd_addr, m1_rvalid);
        end
        @(posedge clk); #1;
        m0_req = 0;
        @(negedge clk);
        n_tests++;
        if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL wr_rd_data: got rv=%b data=%h want 1 deadbeef", m0_rvalid, m0_rdata);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_burst;
        int exp_seq [14] = '{0,0,0,0,1,0,0,0,0,1,0,1,0,1};
        do_reset();
        m0_req = 1; m0_lock = 1; m0_addr = 7'd1;
        m1_req = 1; m1_addr = 7'd2;
        for (int i = 0; i < 14; i++) begin
            if (i == 10) m0_lock = 0;
            @(negedge clk);
            n_tests++;
            if (m0_gnt !== (exp_seq[i] == 0) || m1_gnt !== (exp_seq[i] == 1)) begin
                n_fail++; $display("FAIL burst[%0d]: got %b%b want m%0d", i, m0_gnt, m1_gnt, exp_seq[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_early_unlock;
        int exp_seq [4] = '{0,0,0,1};
        do_reset();
        m0_req = 1; m0_lock = 1; m1_req = 1;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) m0_lock = 0;
            @(negedge clk);
            n_tests++;
            if (m0_gnt !== (exp_seq[i] == 0) || m1_gnt !== (exp_seq[i] == 1)) begin
                n_fail++; $display("FAIL early_unlock[%0d]: got %b%b want m%0d", i, m0_gnt, m1_gnt, exp_seq[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_owner_drop;
        do_reset();
        m0_req = 1; m0_lock = 1; m1_req = 1;
        repeat (2) begin
            @(negedge clk);
            n_tests++;
            if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
                n_fail++; $display("FAIL drop_locked: got %b%b want 10", m0_gnt, m1_gnt);
            end
            @(posedge clk); #1;
        end
        n_tests++;
        if (dut.lock_active !== 1'b1) begin
            n_fail++; $display("FAIL drop_lock_set: got %b want 1", dut.lock_active);
        end
        m0_req = 0;
        @(negedge clk);
        n_tests++;
        if (m0_gnt !== 1'b0 || m1_gnt !== 1'b1) begin
            n_fail++; $display("FAIL drop_gnt: got %b%b want 01", m0_gnt, m1_gnt);
        end
        @(posedge clk); #1;
        n_tests++;
        if (dut.lock_active !== 1'b0) begin
            n_fail++; $display("FAIL drop_lock_clear: got %b want 0", dut.lock_active);
        end
        m0_req = 1; m0_lock = 0;
        @(negedge clk);
        n_tests++;
        if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
            n_fail++; $display("FAIL drop_next: got %b%b want 10", m0_gnt, m1_gnt);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_during_read;
        logic [DW-1:0] d7;
        do_reset();
        d7 = $urandom;
        mem[7] = d7;
        m1_req = 1; m1_addr = 7'd7;
        @(negedge clk);
        n_tests++;
        if (m1_gnt !== 1'b1) begin
            n_fail++; $display("FAIL rr_gnt: got %b want 1", m1_gnt);
        end
        @(posedge clk); #1;
        n_tests++;
        if (m1_rvalid !== 1'b1 || m1_rdata !== d7) begin
            n_fail++; $display("FAIL rr_rvalid: got %b %h want 1 %h", m1_rvalid, m1_rdata, d7);
        end
        #1 rst = 1'b0;
        #1;
        n_tests++;
        if (m1_rvalid !== 1'b0 || m1_gnt !== 1'b0 || m1_rdata !== '0) begin
            n_fail++; $display("FAIL rr_async: got rv=%b gnt=%b d=%h want 0 0 0", m1_rvalid, m1_gnt, m1_rdata);
        end
        m1_req = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++;
            if ({m0_rvalid, m1_rvalid} !== 2'b00) begin
                n_fail++; $display("FAIL rr_stale[%0d]: got %b want 00", i, {m0_rvalid, m1_rvalid});
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random;
        logic          req [2], we [2], lk [2], pend [2];
        logic [AW-1:0] addr [2];
        logic [DW-1:0] wd [2];
        logic [2:0]    st [2];
        logic          exp_rv [2];
        logic [DW-1:0] exp_rd [2];
        int g, m_last, m_owner, m_beats, beats;
        logic [DW-1:0] w;
        do_reset();
        for (int a = 0; a < (1 << AW); a++) begin
            w = $urandom; mem[a] = w; ref_mem[a] = w;
        end
        m_last = 1; m_owner = -1; m_beats = 0;
        for (int m = 0; m < 2; m++) begin
            pend[m] = 0; exp_rv[m] = 0; exp_rd[m] = '0; req[m] = 0;
        end
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int m = 0; m < 2; m++) begin
                if (!pend[m]) begin
                    req[m]  = ($urandom_range(0, 3) != 0);
                    we[m]   = $urandom_range(0, 1) == 1;
                    lk[m]   = ($urandom_range(0, 2) != 0);
                    addr[m] = AW'($urandom_range(0, 15));
                    wd[m]   = $urandom;
                    st[m]   = 3'($urandom_range(0, 7));
                end
            end
            m0_req = req[0]; m0_we = we[0]; m0_lock = lk[0]; m0_addr = addr[0]; m0_wdata = wd[0]; m0_strb = st[0];
            m1_req = req[1]; m1_we = we[1]; m1_lock = lk[1]; m1_addr = addr[1]; m1_wdata = wd[1]; m1_strb = st[1];
            // Reference: a live lock wins, otherwise a lone requester, otherwise not-last
            if (m_owner >= 0 && req[m_owner]) g = m_owner;
            else if (req[0] && req[1]) g = 1 - m_last;
            else if (req[0]) g = 0;
            else if (req[1]) g = 1;
            else g = -1;
            @(negedge clk);
            n_tests++;
            if (m0_gnt !== (g == 0) || m1_gnt !== (g == 1)) begin
                n_fail++; $display("FAIL rand_gnt[%0d]: got %b%b want %0d", cyc, m0_gnt, m1_gnt, g);
            end
            n_tests++;
            if (g < 0 && (mem_we !== 1'b0 || mem_rd_addr !== '0 || mem_wr_addr !== '0 || mem_wr_din !== '0 || mem_wr_strb !== '0)) begin
                n_fail++; $display("FAIL rand_idle_mem[%0d]: got we=%b ra=%h wa=%h din=%h", cyc, mem_we, mem_rd_addr, mem_wr_addr, mem_wr_din);
            end else if (g >= 0 && (mem_we !== we[g] || mem_rd_addr !== addr[g] || mem_wr_addr !== addr[g] ||
                                    mem_wr_din !== wd[g] || mem_wr_strb !== st[g])) begin
                n_fail++; $display("FAIL rand_mem[%0d]: got we=%b ra=%h wa=%h din=%h strb=%b want %b %h %h %h %b",
                                   cyc, mem_we, mem_rd_addr, mem_wr_addr, mem_wr_din, mem_wr_strb,
                                   we[g], addr[g], addr[g], wd[g], st[g]);
            end
            n_tests++;
            if (m0_rvalid !== exp_rv[0] || m1_rvalid !== exp_rv[1] || m0_rdata !== exp_rd[0] || m1_rdata !== exp_rd[1]) begin
                n_fail++; $display("FAIL rand_rdata[%0d]: got %b %b %h %h want %b %b %h %h", cyc,
                                   m0_rvalid, m1_rvalid, m0_rdata, m1_rdata, exp_rv[0], exp_rv[1], exp_rd[0], exp_rd[1]);
            end
            @(posedge clk);
            for (int m = 0; m < 2; m++) begin
                exp_rv[m] = (g == m) && !we[m];
                if (exp_rv[m]) exp_rd[m] = ref_mem[addr[m]];
                pend[m] = req[m] && (g != m);
            end
            if (g >= 0) begin
                if (we[g]) ref_mem[addr[g]] = wd[g];
                m_last = g;
                beats = ((m_owner == g) ? m_beats : 0) + 1;
                if (lk[g] && beats < MB) begin m_owner = g; m_beats = beats; end
                else begin m_owner = -1; m_beats = 0; end
            end else begin
                m_owner = -1; m_beats = 0;
            end
            #1;
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        for (int a = 0; a < (1 << AW); a++) mem[a] = '0;
        test_reset();
        test_fairness();
        test_write_read();
        test_burst();
        test_early_unlock();
        test_owner_drop();
        test_reset_during_read();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
